// File: rtl/auth_key_bank.sv
// auth_key_bank: register-bus key store for the polynomial and Toeplitz hash
// cores, plus a one-time-pad FIFO that masks each outgoing Toeplitz tag with
// exactly one fresh pad.
// Optional feature macro: AUTH_KEY_LOCK_EN (CTRL bit2 locks the key words).
module auth_key_bank #(
    parameter int KEYP_LENGTH = 186,
    parameter int KEYT_LENGTH = 231,
    parameter int TAG_WIDTH   = 40,
    parameter int OTP_DEPTH   = 16,
    parameter int pADDR_WIDTH = 32,
    parameter int pDATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [pADDR_WIDTH-1:0]       awaddr,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [pDATA_WIDTH-1:0]       wdata,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [pADDR_WIDTH-1:0]       araddr,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [pDATA_WIDTH-1:0]       rdata,
    output logic [KEYP_LENGTH-1:0]       polynomial_key,
    output logic [KEYT_LENGTH-1:0]       toeplitz_key,
    input  logic [TAG_WIDTH-1:0]         s_tag_tdata,
    input  logic                         s_tag_tvalid,
    output logic                         s_tag_tready,
    output logic [TAG_WIDTH-1:0]         m_tag_tdata,
    output logic                         m_tag_tvalid,
    input  logic                         m_tag_tready,
    output logic [$clog2(OTP_DEPTH):0]   otp_level
);

    localparam int STRIDE     = pDATA_WIDTH / 8;
    localparam int NP         = (KEYP_LENGTH + pDATA_WIDTH - 1) / pDATA_WIDTH;
    localparam int NT         = (KEYT_LENGTH + pDATA_WIDTH - 1) / pDATA_WIDTH;
    localparam int IDX_OTP    = NP + NT;
    localparam int IDX_STATUS = NP + NT + 1;
    localparam int IDX_CTRL   = NP + NT + 2;
    localparam int PTR_W      = $clog2(OTP_DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    // Architectural state
    logic [pDATA_WIDTH-1:0] poly_q [NP];
    logic [pDATA_WIDTH-1:0] poly_d [NP];
    logic [pDATA_WIDTH-1:0] toep_q [NT];
    logic [pDATA_WIDTH-1:0] toep_d [NT];
    logic [TAG_WIDTH-1:0]   pad_mem_q [OTP_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   ovf_q, ovf_d, stall_q, stall_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   m_valid_q, m_valid_d;
    logic [TAG_WIDTH-1:0]   m_data_q, m_data_d;

    // Bus decode
    logic                   wr_fire, rd_fire, key_wr_ok;
    logic                   otp_push, push_ok, ctrl_wr, flush, pop, full, empty;
    logic [pADDR_WIDTH-1:0] wr_idx, rd_idx;
    logic [pDATA_WIDTH-1:0] rd_val;
    logic                   lock;

    assign wr_fire   = awvalid & wvalid & ~bvalid_q;
    assign awready   = wr_fire;
    assign wready    = wr_fire;
    assign rd_fire   = arvalid & ~rvalid_q;
    assign arready   = ~rvalid_q;
    assign wr_idx    = awaddr / pADDR_WIDTH'(STRIDE);
    assign rd_idx    = araddr / pADDR_WIDTH'(STRIDE);
    assign key_wr_ok = wr_fire & ~lock;
    assign otp_push  = wr_fire & (wr_idx == pADDR_WIDTH'(IDX_OTP));
    assign ctrl_wr   = wr_fire & (wr_idx == pADDR_WIDTH'(IDX_CTRL));
    assign flush     = ctrl_wr & wdata[1];

    assign full      = (level_q == LVL_W'(OTP_DEPTH));
    assign empty     = (level_q == '0);
    assign s_tag_tready = ~empty & (~m_valid_q | m_tag_tready);
    assign pop       = s_tag_tvalid & s_tag_tready;
    // A full FIFO still takes a push when a pad leaves in the same cycle.
    assign push_ok   = otp_push & (~full | pop);

`ifdef AUTH_KEY_LOCK_EN
    logic lock_q, lock_d;
    assign lock_d = lock_q | (ctrl_wr & wdata[2]);
    assign lock   = lock_q;

    // Lock is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) lock_q <= 1'b0;
        else     lock_q <= lock_d;
    end
`else
    assign lock = 1'b0;
`endif

    // Key word updates from the bus; locked writes are dropped
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        for (int i = 0; i < NP; i++) poly_d[i] = poly_q[i];
        for (int i = 0; i < NT; i++) toep_d[i] = toep_q[i];
        if (key_wr_ok) begin
            for (int i = 0; i < NP; i++)
                if (wr_idx == pADDR_WIDTH'(i)) poly_d[i] = wdata;
            for (int i = 0; i < NT; i++)
                if (wr_idx == pADDR_WIDTH'(NP + i)) toep_d[i] = wdata;
        end
    end

    // Read mux: key words (hidden while locked) and STATUS; everything else reads 0
    always_comb begin
        rd_val = '0;
        if (!lock) begin
            for (int i = 0; i < NP; i++)
                if (rd_idx == pADDR_WIDTH'(i)) rd_val = poly_q[i];
            for (int i = 0; i < NT; i++)
                if (rd_idx == pADDR_WIDTH'(NP + i)) rd_val = toep_q[i];
        end
        if (rd_idx == pADDR_WIDTH'(IDX_STATUS)) begin
            rd_val[15:0] = 16'(level_q);
            rd_val[16]   = ovf_q;
            rd_val[17]   = stall_q;
            rd_val[18]   = lock;
        end
    end

    // Bus response channels, pad FIFO bookkeeping, sticky flags and tag stage
    always_comb begin
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        stall_d   = stall_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (wr_fire)     bvalid_d = 1'b1;
        else if (bready) bvalid_d = 1'b0;

        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end else if (rready) begin
            rvalid_d = 1'b0;
        end

        // Flush wins over any same-cycle pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end

        if (ctrl_wr && wdata[0]) begin
            ovf_d   = 1'b0;
            stall_d = 1'b0;
        end
        if (otp_push && !push_ok)    ovf_d   = 1'b1;
        if (s_tag_tvalid && empty)   stall_d = 1'b1;

        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = s_tag_tdata ^ pad_mem_q[rd_ptr_q];
        end else if (m_tag_tready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < NP; i++) poly_q[i] <= '0;
            for (int i = 0; i < NT; i++) toep_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            stall_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            for (int i = 0; i < NP; i++) poly_q[i] <= poly_d[i];
            for (int i = 0; i < NT; i++) toep_q[i] <= toep_d[i];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            stall_q   <= stall_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Pad storage
    always_ff @(posedge clk) begin
        // NOTE: pad storage is not reset; the level counter alone decides which entries are valid.
        if (push_ok) pad_mem_q[wr_ptr_q] <= wdata[TAG_WIDTH-1:0];
    end

    // Key ports: word 0 in the LSBs, truncated to the key length
    always_comb begin
        polynomial_key = '0;
        toeplitz_key   = '0;
        for (int b = 0; b < KEYP_LENGTH; b++)
            polynomial_key[b] = poly_q[b / pDATA_WIDTH][b % pDATA_WIDTH];
        for (int b = 0; b < KEYT_LENGTH; b++)
            toeplitz_key[b] = toep_q[b / pDATA_WIDTH][b % pDATA_WIDTH];
    end

    assign bvalid       = bvalid_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign m_tag_tvalid = m_valid_q;
    assign m_tag_tdata  = m_data_q;
    assign otp_level    = level_q;

endmodule
